// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags for the rename stage.
// Grants one tag per cycle, reclaims committed old tags, and recovers all speculative tags on flush.
module phys_reg_free_list #(
  parameter int PhyRegIDWidth = 6,
  parameter int NumPhyRegs    = 64,
  parameter int NumArRegs     = 32,
  parameter int CommitWidth   = 1,
  localparam int NumFree      = NumPhyRegs - NumArRegs,
  localparam int PtrWidth     = $clog2(NumFree),
  localparam int CntWidth     = $clog2(NumFree + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 alloc_i,
  output logic                                 alloc_valid_o,
  output logic [PhyRegIDWidth-1:0]             alloc_tag_o,
  input  logic [CommitWidth-1:0]               commit_i,
  input  logic [CommitWidth*PhyRegIDWidth-1:0] commit_old_tag_i,
  input  logic                                 flush_i,
  output logic [CntWidth-1:0]                  free_count_o,
  output logic                                 error_o
);

  if (NumFree < 2) begin : g_bad_params
    $error("phys_reg_free_list needs at least two free physical registers");
  end

  logic [PhyRegIDWidth-1:0] free_q [NumFree];
  logic [PhyRegIDWidth-1:0] free_d [NumFree];
  logic [PtrWidth-1:0]      head_q, head_d;
  logic [PtrWidth-1:0]      tail_q, tail_d;
  logic [CntWidth-1:0]      count_q, count_d;
  logic                     error_q, error_d;
  logic                     alloc_fire;

  // Pointers wrap explicitly so NumFree need not be a power of two.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(NumFree - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign alloc_valid_o = (count_q != '0) && !flush_i;
  assign alloc_tag_o   = free_q[head_q];
  assign free_count_o  = count_q;
  assign error_o       = error_q;
  assign alloc_fire    = alloc_i && alloc_valid_o;

  // NOTE: every variable gets a default before any branch so no latch is
  // inferred; blocking assignments here let commit slots chain in order.
  always_comb begin
    free_d  = free_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    error_d = error_q;

    if (alloc_i && !flush_i && (count_q == '0)) error_d = 1'b1;
    if (alloc_fire) begin
      head_d  = ptr_inc(head_q);
      count_d = count_q - CntWidth'(1);
    end

    for (int c = 0; c < CommitWidth; c++) begin
      if (commit_i[c]) begin
        if (count_d == CntWidth'(NumFree)) begin
          error_d = 1'b1;
        end else begin
          free_d[tail_d] = commit_old_tag_i[c*PhyRegIDWidth +: PhyRegIDWidth];
          tail_d         = ptr_inc(tail_d);
          count_d        = count_d + CntWidth'(1);
        end
      end
    end

    // Once in-flight work is discarded every non-architectural tag is free again.
    if (flush_i) begin
      head_d  = tail_d;
      count_d = CntWidth'(NumFree);
    end
  end

  // NOTE: the tag storage is reset because its initial contents are the
  // architecturally meaningful free set, not don't-care data.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumFree; i++) free_q[i] <= PhyRegIDWidth'(NumArRegs + i);
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= CntWidth'(NumFree);
      error_q <= 1'b0;
    end else begin
      free_q  <= free_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      error_q <= error_d;
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Directed self-checking bench for phys_reg_free_list, built with two commit slots.
module tb_phys_reg_free_list;

  localparam int W  = 6;
  localparam int CW = 2;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          alloc_i;
  logic          alloc_valid_o;
  logic [W-1:0]  alloc_tag_o;
  logic [CW-1:0] commit_i;
  logic [CW*W-1:0] commit_old_tag_i;
  logic          flush_i;
  logic [5:0]    free_count_o;
  logic          error_o;

  int n_cmp = 0;
  int n_err = 0;

  phys_reg_free_list #(
    .PhyRegIDWidth(W), .NumPhyRegs(64), .NumArRegs(32), .CommitWidth(CW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .alloc_i(alloc_i), .alloc_valid_o(alloc_valid_o),
    .alloc_tag_o(alloc_tag_o), .commit_i(commit_i), .commit_old_tag_i(commit_old_tag_i),
    .flush_i(flush_i), .free_count_o(free_count_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " valid"}, 32'(alloc_valid_o), 1);
    check({tag, " tag"},   32'(alloc_tag_o),   32);
    check({tag, " count"}, 32'(free_count_o),  32);
    check({tag, " error"}, 32'(error_o),       0);
  endtask

  // Inputs change on the falling edge; #1 later the same-cycle outputs settle.
  task automatic drive(input logic a, input logic [CW-1:0] c, input int t0, input int t1,
                       input logic f);
    @(negedge clk_i);
    alloc_i          = a;
    commit_i         = c;
    commit_old_tag_i = {W'(t1), W'(t0)};
    flush_i          = f;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; alloc_i = 1'b0; commit_i = '0; commit_old_tag_i = '0; flush_i = 1'b0;
    #1 check_reset_outputs("in_reset");
    @(negedge clk_i) rst_i = 1'b0;

    drive(0, 2'b00, 0, 0, 0);
    check_reset_outputs("idle");

    for (int i = 0; i < 32; i++) begin
      drive(1, 2'b00, 0, 0, 0);
      check($sformatf("grant%0d tag", i), 32'(alloc_tag_o), 32 + i);
      check($sformatf("grant%0d valid", i), 32'(alloc_valid_o), 1);
    end
    drive(1, 2'b00, 0, 0, 0);
    check("empty valid", 32'(alloc_valid_o), 0);
    check("empty count", 32'(free_count_o), 0);
    check("empty err_before", 32'(error_o), 0);
    drive(0, 2'b00, 0, 0, 0);
    check("underflow error", 32'(error_o), 1);
    check("underflow count", 32'(free_count_o), 0);
    check("underflow head", 32'(alloc_tag_o), 32);

    drive(0, 2'b01, 5, 0, 0);
    check("no_bypass valid", 32'(alloc_valid_o), 0);
    drive(0, 2'b00, 0, 0, 0);
    check("push5 valid", 32'(alloc_valid_o), 1);
    check("push5 tag", 32'(alloc_tag_o), 5);
    check("push5 count", 32'(free_count_o), 1);

    drive(1, 2'b01, 9, 0, 0);
    check("net grant tag", 32'(alloc_tag_o), 5);
    check("net grant valid", 32'(alloc_valid_o), 1);
    drive(0, 2'b00, 0, 0, 0);
    check("net count", 32'(free_count_o), 1);
    check("net tag", 32'(alloc_tag_o), 9);

    drive(0, 2'b11, 7, 8, 0);
    drive(0, 2'b00, 0, 0, 0);
    check("dual count", 32'(free_count_o), 3);
    drive(1, 2'b00, 0, 0, 0);
    check("dual g0", 32'(alloc_tag_o), 9);
    drive(1, 2'b00, 0, 0, 0);
    check("dual g1", 32'(alloc_tag_o), 7);
    drive(1, 2'b00, 0, 0, 0);
    check("dual g2", 32'(alloc_tag_o), 8);
    drive(0, 2'b00, 0, 0, 0);
    check("dual drained", 32'(free_count_o), 0);

    // Asynchronous reset must act between edges.
    @(negedge clk_i) rst_i = 1'b1;
    #1 check_reset_outputs("async_reset");
    @(negedge clk_i) rst_i = 1'b0;

    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b00, 0, 0, 0);
      check($sformatf("pre_flush%0d tag", i), 32'(alloc_tag_o), 32 + i);
    end
    drive(1, 2'b00, 0, 0, 1);
    check("flush valid", 32'(alloc_valid_o), 0);
    drive(0, 2'b00, 0, 0, 0);
    check("flush count", 32'(free_count_o), 32);
    check("flush tag", 32'(alloc_tag_o), 32);
    check("flush error", 32'(error_o), 0);

    drive(0, 2'b01, 3, 0, 0);
    drive(0, 2'b00, 0, 0, 0);
    check("overflow error", 32'(error_o), 1);
    check("overflow count", 32'(free_count_o), 32);
    check("overflow tag", 32'(alloc_tag_o), 32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
